// File: rtl/pc_fetch_ctrl.sv
// IF-stage sequencer: owns the PC, issues one imem fetch at a time,
// squashes in-flight fetches on redirect and hands words to IF/ID.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        flush,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT
    } state_t;

    state_t      state;
    logic        drop;
    logic [31:0] fetch_pc;
    logic [31:0] tgt;
    logic        fire;
    logic        unused_bits;

    assign tgt         = {next_pc[31:2], 2'b00};
    assign unused_bits = ^next_pc[1:0];

    // A held, stalled instruction blocks the next request
    assign imem_req  = (state == S_REQ) && !(if_valid && stall);
    assign imem_addr = pc;
    assign fire      = imem_req && imem_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_BOOT;
            pc       <= {RESET_PC[31:2], 2'b00};
            fetch_pc <= 32'h0;
            drop     <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_instr <= 32'h0;
        end else begin
            unique case (state)
                S_BOOT: begin
                    state <= S_REQ;
                    if (flush) begin
                        pc       <= tgt;
                        if_valid <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (if_valid && !stall) begin
                        if_valid <= 1'b0;
                    end
                    if (fire) begin
                        fetch_pc <= pc;
                        pc       <= pc + 32'd4;
                        state    <= S_WAIT;
                    end
                    if (flush) begin
                        pc       <= tgt;
                        if_valid <= 1'b0;
                        drop     <= fire;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        pc       <= tgt;
                        if_valid <= 1'b0;
                    end
                    if (imem_rvalid) begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                        if (!drop && !flush) begin
                            if_instr <= imem_rdata;
                            if_pc    <= fetch_pc;
                            if_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule
